// File: rtl/alu_result_fifo.sv
// Result FIFO behind the ALU result mux: buffers {result, zero, carry, overflow}
// and hands them to the consumer over valid/ready. Optional RESFIFO_BYPASS_EN fall-through.
module alu_result_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_result,
    input  logic                       in_carry,
    input  logic                       in_overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_zero,
    output logic                       out_carry,
    output logic                       out_overflow,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             carry;
        logic             overflow;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        in_entry;
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          ready_q, valid_q, ready_nxt, valid_nxt;
    logic          push, pop, bypass;

    // Zero flag is resolved at write time so the head needs no compare.
    assign in_entry = {in_result, (in_result == '0), in_carry, in_overflow};

`ifdef RESFIFO_BYPASS_EN
    assign bypass = ready_q & in_valid & out_ready & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push = in_valid & ready_q & ~bypass;
    assign pop  = valid_q & out_ready;

    // Next-state for pointers, occupancy and the registered handshake flags.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (push) wr_ptr_nxt = wr_ptr + AW'(1);
        if (pop)  rd_ptr_nxt = rd_ptr + AW'(1);
        count_nxt = count + CW'(push) - CW'(pop);
        ready_nxt = (count_nxt != CW'(DEPTH));
        valid_nxt = (count_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            count   <= count_nxt;
            ready_q <= ready_nxt;
            valid_q <= valid_nxt;
        end
    end

    // Storage needs no reset: the output mux hides it whenever valid_q is low.
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= in_entry;
    end

    always_comb begin
        head = '0;
        if (bypass)       head = in_entry;
        else if (valid_q) head = mem[rd_ptr];
    end

    assign in_ready     = ready_q;
    assign out_valid    = valid_q | bypass;
    assign out_result   = head.result;
    assign out_zero     = head.zero;
    assign out_carry    = head.carry;
    assign out_overflow = head.overflow;

endmodule
